// File: rtl/jelly_data_logger_trigger.sv
`default_nettype none
// ============================================================================
// Module   : jelly_data_logger_trigger
// Brief    : Pre/post-trigger sample capture through a ring buffer to a logger.
// Revision : 1.0
// ============================================================================
module jelly_data_logger_trigger #(
  parameter int DATA_WIDTH    = 32,
  parameter int BUF_PTR_WIDTH = 4,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ctl_arm,
  input  logic                     ctl_abort,
  input  logic [DATA_WIDTH-1:0]    param_trig_mask,
  input  logic [DATA_WIDTH-1:0]    param_trig_value,
  input  logic [BUF_PTR_WIDTH-1:0] param_pre_count,
  input  logic [COUNT_WIDTH-1:0]   param_post_count,
  input  logic [DATA_WIDTH-1:0]    s_data,
  input  logic                     s_valid,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [1:0]               status_state,
  output logic                     status_overflow
);

  localparam int DEPTH = 1 << BUF_PTR_WIDTH;
  localparam logic [BUF_PTR_WIDTH+1:0] OCC_FULL = (BUF_PTR_WIDTH+2)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [BUF_PTR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [BUF_PTR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]    mask_q, mask_d;
  logic [DATA_WIDTH-1:0]    value_q, value_d;
  logic [BUF_PTR_WIDTH-1:0] pre_q, pre_d;
  logic [COUNT_WIDTH-1:0]   post_q, post_d;
  logic [COUNT_WIDTH-1:0]   post_cnt_q, post_cnt_d;
  logic                     overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]    m_data_q, m_data_d;
  logic                     m_valid_q, m_valid_d;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic [BUF_PTR_WIDTH:0]   w_count;
  logic [BUF_PTR_WIDTH+1:0] w_occ;
  logic                     w_empty;
  logic                     w_full;
  logic                     w_trig;
  logic                     w_rd_en;
  logic                     w_out_pop;
  logic                     w_wr_en;

  assign w_count   = wr_ptr_q - rd_ptr_q;
  assign w_empty   = (wr_ptr_q == rd_ptr_q);
  // The output register counts toward capacity, so total storage never exceeds DEPTH.
  assign w_occ     = {1'b0, w_count} + (BUF_PTR_WIDTH+2)'(m_valid_q);
  assign w_full    = (w_occ >= OCC_FULL);
  assign w_trig    = s_valid && (((s_data ^ value_q) & mask_q) == '0);
  assign w_out_pop = m_valid_q && m_ready;
  assign w_rd_en   = ((state_q == ST_CAPTURE) || (state_q == ST_DRAIN)) && !w_empty
                     && (!m_valid_q || m_ready);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mask_d     = mask_q;
    value_d    = value_q;
    pre_d      = pre_q;
    post_d     = post_q;
    post_cnt_d = post_cnt_q;
    overflow_d = overflow_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    w_wr_en    = 1'b0;

    if (w_rd_en) begin
      m_valid_d = 1'b1;
      m_data_d  = mem[rd_ptr_q[BUF_PTR_WIDTH-1:0]];
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (ctl_arm) begin
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          overflow_d = 1'b0;
          mask_d     = param_trig_mask;
          value_d    = param_trig_value;
          pre_d      = param_pre_count;
          post_d     = param_post_count;
          state_d    = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (s_valid) begin
          w_wr_en  = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (w_trig) begin
            post_cnt_d = post_q;
            state_d    = (post_q == '0) ? ST_DRAIN : ST_CAPTURE;
          end else if (w_count == {1'b0, pre_q}) begin
            // History window is full: retire the oldest sample as the new one lands.
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        if (s_valid) begin
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == COUNT_WIDTH'(1)) begin
            state_d = ST_DRAIN;
          end
          if (!w_full || w_out_pop) begin
            w_wr_en  = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (w_empty && (!m_valid_q || m_ready)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ctl_abort) begin
      state_d   = ST_IDLE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      m_valid_d = 1'b0;
      m_data_d  = '0;
      w_wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mask_q     <= '0;
      value_q    <= '0;
      pre_q      <= '0;
      post_q     <= '0;
      post_cnt_q <= '0;
      overflow_q <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mask_q     <= mask_d;
      value_q    <= value_d;
      pre_q      <= pre_d;
      post_q     <= post_d;
      post_cnt_q <= post_cnt_d;
      overflow_q <= overflow_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en && !reset) begin
      mem[wr_ptr_q[BUF_PTR_WIDTH-1:0]] <= s_data;
    end
  end

  assign m_data          = m_data_q;
  assign m_valid         = m_valid_q;
  assign status_state    = state_q;
  assign status_overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_jelly_data_logger_trigger.sv
`default_nettype none
// ============================================================================
// Module   : tb_jelly_data_logger_trigger
// Brief    : Directed self-checking bench for jelly_data_logger_trigger.
// Revision : 1.0
// ============================================================================
module tb_jelly_data_logger_trigger;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctl_arm;
  logic        ctl_abort;
  logic [31:0] param_trig_mask;
  logic [31:0] param_trig_value;
  logic [3:0]  param_pre_count;
  logic [15:0] param_post_count;
  logic [31:0] s_data;
  logic        s_valid;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [1:0]  status_state;
  logic        status_overflow;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] q[$];
  logic [31:0] exp_q[$];
  bit          toggle = 1'b0;
  bit          chk_stable = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always #5 clk = ~clk;

  jelly_data_logger_trigger #(
    .DATA_WIDTH   (32),
    .BUF_PTR_WIDTH(4),
    .COUNT_WIDTH  (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ctl_arm         (ctl_arm),
    .ctl_abort       (ctl_abort),
    .param_trig_mask (param_trig_mask),
    .param_trig_value(param_trig_value),
    .param_pre_count (param_pre_count),
    .param_post_count(param_post_count),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .status_state    (status_state),
    .status_overflow (status_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Collect accepted words and verify hold-while-stalled between edges.
  always @(negedge clk) begin
    if (m_valid && m_ready) q.push_back(m_data);
    if (chk_stable && prev_stall) begin
      chk("stall_valid", {31'b0, m_valid}, 32'd1);
      chk("stall_data", m_data, prev_data);
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle) m_ready = ~m_ready;
  endtask

  task automatic send(input logic [31:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic arm(input logic [31:0] mask, input logic [31:0] value,
                     input logic [3:0] pre, input logic [15:0] post);
    param_trig_mask  = mask;
    param_trig_value = value;
    param_pre_count  = pre;
    param_post_count = post;
    ctl_arm = 1'b1;
    tick();
    ctl_arm = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (status_state != 2'd0 && n < max) begin
      tick();
      n++;
    end
    chk(tag, {30'b0, status_state}, 32'd0);
  endtask

  task automatic check_q(input string tag);
    chk({tag, "_count"}, 32'(q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < q.size(); i++) begin
      chk(tag, q[i], exp_q[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; ctl_arm = 1'b0; ctl_abort = 1'b0;
    param_trig_mask = '0; param_trig_value = '0; param_pre_count = '0; param_post_count = '0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_state", {30'b0, status_state}, 32'd0);
    chk("rst_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_ovf", {31'b0, status_overflow}, 32'd0);

    // Basic pre/post capture; trigger value changed after arm must be ignored.
    q.delete();
    arm(32'hFF, 32'h10, 4'd3, 16'd2);
    chk("arm_state", {30'b0, status_state}, 32'd1);
    param_trig_value = 32'h05;
    for (int i = 1; i <= 20; i++) begin
      send(32'(i));
      if (i == 16) chk("trig_state", {30'b0, status_state}, 32'd2);
    end
    wait_idle("basic_idle", 50);
    exp_q = '{32'd13, 32'd14, 32'd15, 32'h10, 32'd17, 32'd18};
    check_q("basic");

    // Same capture with a toggling sink.
    q.delete();
    arm(32'hFF, 32'h10, 4'd3, 16'd2);
    toggle = 1'b1; chk_stable = 1'b1;
    for (int i = 1; i <= 20; i++) send(32'(i));
    wait_idle("stall_idle", 100);
    toggle = 1'b0; chk_stable = 1'b0; m_ready = 1'b1;
    check_q("stall");
    chk("stall_ovf", {31'b0, status_overflow}, 32'd0);

    // Full buffer with blocked sink: post samples dropped, overflow sticks.
    q.delete();
    m_ready = 1'b0;
    arm(32'hFF, 32'hEE, 4'd15, 16'd10);
    for (int i = 1; i <= 15; i++) send(32'(i));
    send(32'hEE);
    for (int i = 0; i < 10; i++) send(32'h20 + 32'(i));
    chk("full_state", {30'b0, status_state}, 32'd3);
    chk("full_ovf", {31'b0, status_overflow}, 32'd1);
    chk("full_held", 32'(q.size()), 32'd0);
    m_ready = 1'b1;
    wait_idle("full_idle", 60);
    exp_q.delete();
    for (int i = 1; i <= 15; i++) exp_q.push_back(32'(i));
    exp_q.push_back(32'hEE);
    check_q("full");

    // Zero mask triggers on the first sample; zero post goes straight to drain.
    q.delete();
    arm(32'h0, 32'h0, 4'd5, 16'd0);
    chk("mask0_ovf_clr", {31'b0, status_overflow}, 32'd0);
    send(32'hAA);
    chk("mask0_state", {30'b0, status_state}, 32'd3);
    wait_idle("mask0_idle", 20);
    exp_q = '{32'hAA};
    check_q("mask0");

    // Abort during capture flushes everything.
    q.delete();
    m_ready = 1'b0;
    arm(32'hFF, 32'h80, 4'd3, 16'd5);
    for (int i = 1; i <= 5; i++) send(32'(i));
    send(32'h80);
    chk("abort_cap_state", {30'b0, status_state}, 32'd2);
    chk("abort_pre_valid0", {31'b0, m_valid}, 32'd0);
    tick();
    chk("abort_pre_valid1", {31'b0, m_valid}, 32'd1);
    chk("abort_pre_data", m_data, 32'd3);
    ctl_abort = 1'b1;
    tick();
    ctl_abort = 1'b0;
    chk("abort_valid", {31'b0, m_valid}, 32'd0);
    chk("abort_state", {30'b0, status_state}, 32'd0);
    m_ready = 1'b1;
    repeat (5) tick();
    chk("abort_no_out", 32'(q.size()), 32'd0);

    // Reset while armed discards history.
    q.delete();
    arm(32'hFF, 32'h55, 4'd3, 16'd0);
    send(32'd1); send(32'd2); send(32'd3);
    chk("rst2_armed", {30'b0, status_state}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_state", {30'b0, status_state}, 32'd0);
    chk("rst2_valid", {31'b0, m_valid}, 32'd0);
    repeat (3) tick();
    chk("rst2_no_out", 32'(q.size()), 32'd0);
    arm(32'hFF, 32'h55, 4'd0, 16'd0);
    send(32'h55);
    wait_idle("rst2_idle", 20);
    exp_q = '{32'h55};
    check_q("rst2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jelly_data_logger_trigger.md
JELLY_DATA_LOGGER_TRIGGER -- requirements
Module: jelly_data_logger_trigger

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, sample/output data width.
REQ-002 SHALL have parameter BUF_PTR_WIDTH, default 4, ring buffer depth = 2^BUF_PTR_WIDTH entries.
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, width of post-trigger counter.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ctl_arm  input  1  one-cycle pulse; starts a capture from IDLE.
REQ-007 SHALL have port ctl_abort  input  1  one-cycle pulse; forces return to IDLE.
REQ-008 SHALL have port param_trig_mask  input  DATA_WIDTH  bits compared for trigger.
REQ-009 SHALL have port param_trig_value  input  DATA_WIDTH  trigger compare value.
REQ-010 SHALL have port param_pre_count  input  BUF_PTR_WIDTH  samples kept before trigger.
REQ-011 SHALL have port param_post_count  input  COUNT_WIDTH  samples captured after trigger sample.
REQ-012 SHALL have port s_data  input  DATA_WIDTH  sample data.
REQ-013 SHALL have port s_valid  input  1  sample strobe; no ready, never back-pressured.
REQ-014 SHALL have port m_data  output  DATA_WIDTH  data toward the logger FIFO.
REQ-015 SHALL have port m_valid  output  1  output valid.
REQ-016 SHALL have port m_ready  input  1  output ready.
REQ-017 SHALL have port status_state  output  2  0=IDLE,1=ARMED,2=CAPTURE,3=DRAIN.
REQ-018 SHALL have port status_overflow  output  1  sticky: sample dropped in CAPTURE.

Function
REQ-019 SHALL implement a state machine IDLE -> ARMED -> CAPTURE -> DRAIN -> IDLE.
REQ-020 IDLE SHALL ignore s_valid; ctl_arm SHALL empty buffer, clear status_overflow, latch params, enter ARMED next cycle.
REQ-021 ARMED: each s_valid sample not matching trigger SHALL be written to ring; if occupancy would exceed latched pre_count, oldest entry SHALL be discarded same cycle (pre_count=0 keeps nothing).
REQ-022 ARMED SHALL emit nothing on m (m_valid=0).
REQ-023 Trigger SHALL be s_valid && ((s_data ^ param_trig_value) & param_trig_mask)==0; mask all-zero triggers on first valid sample.
REQ-024 On trigger the trigger sample SHALL be written, post counter loaded with latched post_count, state -> CAPTURE.
REQ-025 CAPTURE: each s_valid SHALL write one sample and decrement counter; when counter reaches 0 with no further write pending, state -> DRAIN; post_count=0 enters DRAIN directly from trigger.
REQ-026 CAPTURE: write while buffer full SHALL drop the sample, set status_overflow, still decrement counter.
REQ-027 CAPTURE/DRAIN: buffer SHALL drain to m in write order; simultaneous read and write when full SHALL succeed (no drop).
REQ-028 DRAIN: s_valid ignored; when buffer empty and no output pending, state -> IDLE.
REQ-029 m_data/m_valid SHALL be registered; a written sample SHALL appear on m no earlier than 1 cycle after its write, sustaining 1 word/cycle with m_ready high.
REQ-030 While m_valid && !m_ready, m_data and m_valid SHALL hold stable.
REQ-031 ctl_abort SHALL win over all events: buffer and output register flushed, m_valid=0, state IDLE next cycle; status_overflow retained.
REQ-032 ctl_arm outside IDLE SHALL be ignored; param changes after arm SHALL not affect the running capture.
REQ-033 Buffer pointers SHALL wrap modulo 2^BUF_PTR_WIDTH; full/empty distinguished with an extra pointer bit; max pre-trigger samples = 2^BUF_PTR_WIDTH-1.

Reset
REQ-034 reset SHALL force state IDLE, buffer empty, m_valid=0, m_data=0, status_overflow=0, post counter 0.
REQ-035 reset mid-capture SHALL discard all buffered samples; no word SHALL be emitted after reset deasserts until a new arm+trigger.

Verification
REQ-036 pre=3,post=2,mask=FF,value=0x10, samples 1..20 with 0x10 at index 16, m_ready=1 -> m emits 13,14,15,16(0x10),17,18 then IDLE.
REQ-037 Same as REQ-036 with m_ready toggling 50% -> identical sequence, data stable while stalled, no overflow.
REQ-038 BUF_PTR_WIDTH=4, pre=15, post=10, m_ready=0 during capture -> 16 words kept, status_overflow=1, after release exactly 16 words emitted.
REQ-039 mask=0, pre=5, post=0, arm then sample 0xAA -> single word 0xAA, state returns IDLE.
REQ-040 ctl_abort during CAPTURE with 4 buffered words -> m_valid=0 next cycle, state IDLE, no further output.
REQ-041 reset asserted in ARMED with 3 buffered samples, then arm and trigger on 0x55 with pre=0, post=0 -> only 0x55 emitted.
